// File: rtl/div_if.sv
// Level req/ready handshake bundle between the ALU and the iterative divider.
// With DIV_SIGNED_EN defined, the bundle also carries signed_op, which is sampled with the operands.
interface div_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
`ifdef DIV_SIGNED_EN
    logic              signed_op;
`endif
    logic              ready;
    logic [2*XLEN-1:0] result;

`ifdef DIV_SIGNED_EN
    modport master (output req, a, b, signed_op, input ready, result);
    modport slave  (input req, a, b, signed_op, output ready, result);
`else
    modport master (output req, a, b, input ready, result);
    modport slave  (input req, a, b, output ready, result);
`endif
endinterface

// File: rtl/div.sv
// Iterative radix-2 restoring divider. The result is {remainder, quotient}, and it is registered.
// Defining DIV_SIGNED_EN enables signed division, selected per operation by bus.signed_op.
module div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   rem, rem_next;
    logic [XLEN-1:0]   quo, quo_next;
    logic [XLEN-1:0]   divisor, divisor_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ready_reg, ready_next;
    logic [2*XLEN-1:0] result_reg, result_next;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    logic neg_quo, neg_quo_next;
    logic neg_rem, neg_rem_next;
    logic a_neg, b_neg, overflow;

    assign a_neg    = bus.signed_op & bus.a[XLEN-1];
    assign b_neg    = bus.signed_op & bus.b[XLEN-1];
    assign a_mag    = a_neg ? -bus.a : bus.a;
    assign b_mag    = b_neg ? -bus.b : bus.b;
    assign overflow = bus.signed_op && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    always_comb begin
        state_next   = state;
        rem_next     = rem;
        quo_next     = quo;
        divisor_next = divisor;
        cnt_next     = cnt;
        ready_next   = 1'b0;
        result_next  = '0;
`ifdef DIV_SIGNED_EN
        neg_quo_next = neg_quo;
        neg_rem_next = neg_rem;
`endif
        // The trial subtraction uses the full remainder so that divisors with the MSB set still divide correctly.
        trial = {rem, quo[XLEN-1]} - {1'b0, divisor};

        case (state)
            IDLE: begin
                if (bus.req) begin
                    divisor_next = b_mag;
                    rem_next     = '0;
                    quo_next     = a_mag;
                    cnt_next     = CNT_W'(XLEN);
                    state_next   = BUSY;
`ifdef DIV_SIGNED_EN
                    neg_quo_next = a_neg ^ b_neg;
                    neg_rem_next = a_neg;
`endif
                    if (bus.b == '0) begin
                        quo_next   = '1;
                        rem_next   = bus.a;
                        state_next = DONE;
                    end
`ifdef DIV_SIGNED_EN
                    else if (overflow) begin
                        quo_next   = bus.a;
                        rem_next   = '0;
                        state_next = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (!bus.req) begin
                    state_next = IDLE;
                end else begin
                    if (!trial[XLEN]) begin
                        rem_next = trial[XLEN-1:0];
                        quo_next = {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem_next = {rem[XLEN-2:0], quo[XLEN-1]};
                        quo_next = {quo[XLEN-2:0], 1'b0};
                    end
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_next = DONE;
`ifdef DIV_SIGNED_EN
                        if (neg_quo) quo_next = -quo_next;
                        if (neg_rem) rem_next = -rem_next;
`endif
                    end
                end
            end
            DONE: begin
                if (bus.req) begin
                    ready_next  = 1'b1;
                    result_next = {rem, quo};
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            cnt        <= '0;
            ready_reg  <= 1'b0;
            result_reg <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            rem        <= rem_next;
            quo        <= quo_next;
            divisor    <= divisor_next;
            cnt        <= cnt_next;
            ready_reg  <= ready_next;
            result_reg <= result_next;
`ifdef DIV_SIGNED_EN
            neg_quo    <= neg_quo_next;
            neg_rem    <= neg_rem_next;
`endif
        end
    end

    assign bus.ready  = ready_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_div.sv
// Randomised bench for div. A time-based reference model predicts ready and result on every cycle.
// Literal cases pin the model and the latency figures.
module tb_div;
    localparam int XLEN = 32;
    localparam int RW   = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_sgn = 1'b0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_if #(.XLEN(XLEN)) bus();

    div #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] model_result(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                   input logic sgn);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic signed [XLEN-1:0] sq;
        logic signed [XLEN-1:0] sr;
        if (b == '0) return {a, {XLEN{1'b1}}};
        if (sgn) begin
            sa = a;
            sb = b;
            if (a == MIN_NEG && b == {XLEN{1'b1}}) return {{XLEN{1'b0}}, a};
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    function automatic int model_latency(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn);
        if (b == '0) return 1;
        if (sgn && a == MIN_NEG && b == {XLEN{1'b1}}) return 1;
        return XLEN + 1;
    endfunction

    // The reference model is an operation timeline: capture, then a fixed latency, then hold until req drops.
    logic          m_active = 1'b0;
    int            m_k = 0;
    int            m_lat = 0;
    logic [RW-1:0] m_res = '0;
    logic          exp_ready = 1'b0;
    logic [RW-1:0] exp_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            exp_ready  = 1'b0;
            exp_result = '0;
        end else if (!m_active) begin
            if (bus.req) begin
                m_active = 1'b1;
                m_k      = 0;
                m_lat    = model_latency(bus.a, bus.b, drv_sgn);
                m_res    = model_result(bus.a, bus.b, drv_sgn);
            end
        end else begin
            m_k++;
            if (!bus.req) begin
                m_active   = 1'b0;
                exp_ready  = 1'b0;
                exp_result = '0;
            end else if (m_k >= m_lat) begin
                exp_ready  = 1'b1;
                exp_result = m_res;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [RW-1:0] actual, input logic [RW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_ready", RW'(bus.ready), RW'(exp_ready));
            checkOutput("cyc_result", bus.result, exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn);
        bus.a   = a;
        bus.b   = b;
        drv_sgn = sgn;
`ifdef DIV_SIGNED_EN
        bus.signed_op = sgn;
`endif
        bus.req = 1'b1;
    endtask

    task automatic waitReady(input int budget, output int edges);
        edges = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            edges++;
            if (bus.ready) return;
        end
        edges = -2;
    endtask

    task automatic dropReq();
        bus.req = 1'b0;
        tick();
        checkOutput("drop_ready", RW'(bus.ready), RW'(0));
        checkOutput("drop_result", bus.result, RW'(0));
    endtask

    task automatic runOp(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn,
                         input int exp_lat, input logic [RW-1:0] exp_res);
        int edges;
        applyStimulus(a, b, sgn);
        waitReady(60, edges);
        checkOutput({name, "_lat"}, RW'(edges), RW'(exp_lat));
        checkOutput({name, "_res"}, bus.result, exp_res);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        logic            rs;
        int              hold;
        int              edges;

        bus.req = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
`ifdef DIV_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        repeat (3) tick();
        cmp_en = 1'b1;
        checkOutput("reset_ready", RW'(bus.ready), RW'(0));
        checkOutput("reset_result", bus.result, RW'(0));
        rst = 1'b0;

        checkOutput("model_100_7", model_result(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        checkOutput("model_max_1", model_result(32'hFFFFFFFF, 32'd1, 1'b0), {32'd0, 32'hFFFFFFFF});
        checkOutput("model_5_9", model_result(32'd5, 32'd9, 1'b0), {32'd5, 32'd0});
        checkOutput("model_42_0", model_result(32'd42, 32'd0, 1'b0), {32'd42, 32'hFFFFFFFF});
        checkOutput("model_lat_div0", RW'(model_latency(32'd42, 32'd0, 1'b0)), RW'(1));

        runOp("t1", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14});
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_ready", RW'(bus.ready), RW'(1));
            checkOutput("hold_result", bus.result, {32'd2, 32'd14});
        end
        dropReq();

        runOp("max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFFFFFF});
        dropReq();
        runOp("small", 32'd5, 32'd9, 1'b0, 33, {32'd5, 32'd0});
        dropReq();
        runOp("div0", 32'd42, 32'd0, 1'b0, 1, {32'd42, 32'hFFFFFFFF});
        dropReq();
        runOp("zero_dividend", 32'd0, 32'd13, 1'b0, 33, {32'd0, 32'd0});
        dropReq();
        runOp("big_divisor", 32'hFFFFFFFF, 32'h80000001, 1'b0, 33, {32'h7FFFFFFE, 32'd1});
        dropReq();

        // An abort at edge 10 is followed by a fresh capture on the next edge.
        applyStimulus(32'd1000, 32'd3, 1'b0);
        repeat (10) tick();
        bus.req = 1'b0;
        tick();
        checkOutput("abort_ready", RW'(bus.ready), RW'(0));
        runOp("after_abort", 32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3});
        dropReq();

        applyStimulus(32'd77, 32'd5, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_ready", RW'(bus.ready), RW'(0));
        checkOutput("midrst_result", bus.result, RW'(0));
        rst     = 1'b0;
        bus.req = 1'b0;
        tick();

        runOp("pre_rst", 32'd50, 32'd6, 1'b0, 33, {32'd2, 32'd8});
        rst = 1'b1;
        tick();
        checkOutput("donerst_ready", RW'(bus.ready), RW'(0));
        checkOutput("donerst_result", bus.result, RW'(0));
        rst     = 1'b0;
        bus.req = 1'b0;
        tick();

`ifdef DIV_SIGNED_EN
        runOp("s_neg7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        dropReq();
        runOp("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, {32'd0, 32'h80000000});
        dropReq();
        runOp("s_div0", 32'hFFFFFFFB, 32'd0, 1'b1, 1, {32'hFFFFFFFB, 32'hFFFFFFFF});
        dropReq();
`endif

        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom;
                3:       rb = $urandom | 32'h80000000;
                default: rb = $urandom_range(1, 1000);
            endcase
            if ($urandom_range(0, 9) == 0) ra = '0;
`ifdef DIV_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, rs);
            tick();
            bus.a = $urandom;
            bus.b = $urandom;
            hold  = $urandom_range(0, 40);
            repeat (hold) tick();
            dropReq();
            if ($urandom_range(0, 1) == 1) tick();
        end

        applyStimulus(32'd1234, 32'd10, 1'b0);
        waitReady(60, edges);
        checkOutput("final_lat", RW'(edges), RW'(33));
        dropReq();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
